// File: rtl/commit_preg_release.sv
// Retirement RAT: returns stale pregs to the free list and streams the committed map on recovery.
// Optional FREE_STATS_EN builds a running count of freed pregs on freed_total.
module commit_preg_release #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32,
  parameter int COMMIT_WIDTH  = 4,
  parameter int WALK_WIDTH    = 4,
  parameter int PREG_BITS     = $clog2(NUM_PHYS_REGS)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [COMMIT_WIDTH-1:0]                commit_valid,
  input  logic [COMMIT_WIDTH-1:0]                commit_has_dest,
  input  logic [COMMIT_WIDTH-1:0][4:0]           commit_arch_rd,
  input  logic [COMMIT_WIDTH-1:0][PREG_BITS-1:0] commit_new_preg,
  output logic                                   commit_ready,
  output logic [COMMIT_WIDTH-1:0]                free_req,
  output logic [COMMIT_WIDTH-1:0][PREG_BITS-1:0] free_preg,
  input  logic                                   recover_req,
  output logic                                   walk_valid,
  output logic [4:0]                             walk_arch_base,
  output logic [WALK_WIDTH-1:0][PREG_BITS-1:0]   walk_preg,
  output logic                                   walk_done,
  output logic                                   busy,
  output logic [31:0]                            freed_total
);

  localparam int NUM_BEATS = NUM_ARCH_REGS / WALK_WIDTH;
  localparam int CNT_BITS  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int FCNT_BITS = $clog2(COMMIT_WIDTH + 1);
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(NUM_BEATS - 1);

  typedef enum logic {IDLE, WALK} state_e;

  state_e                                 state_q, state_d;
  logic [CNT_BITS-1:0]                    walk_cnt_q, walk_cnt_d;
  logic [PREG_BITS-1:0]                   rrat_q [NUM_ARCH_REGS];
  logic [PREG_BITS-1:0]                   rrat_d [NUM_ARCH_REGS];
  logic [COMMIT_WIDTH-1:0]                free_req_q, free_req_d;
  logic [COMMIT_WIDTH-1:0][PREG_BITS-1:0] free_preg_q, free_preg_d;
  logic [FCNT_BITS-1:0]                   fcnt;
  logic [PREG_BITS-1:0]                   freed;

  assign commit_ready = (state_q == IDLE);

  // rrat_d is updated slot by slot, so a younger slot sees older same-cycle writes.
  always_comb begin
    rrat_d      = rrat_q;
    free_req_d  = '0;
    free_preg_d = '0;
    fcnt        = '0;
    freed       = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (commit_valid[i] && commit_ready && commit_has_dest[i]) begin
        if (commit_arch_rd[i] == 5'd0) begin
          freed = commit_new_preg[i];
        end else begin
          freed = rrat_d[commit_arch_rd[i]];
          rrat_d[commit_arch_rd[i]] = commit_new_preg[i];
        end
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
          if (FCNT_BITS'(k) == fcnt) free_preg_d[k] = freed;
        end
        fcnt = fcnt + FCNT_BITS'(1);
      end
    end
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      free_req_d[k] = (FCNT_BITS'(k) < fcnt);
    end
  end

  always_comb begin
    state_d    = state_q;
    walk_cnt_d = walk_cnt_q;
    case (state_q)
      IDLE: begin
        walk_cnt_d = '0;
        if (recover_req) state_d = WALK;
      end
      WALK: begin
        if (walk_cnt_q == LAST_BEAT) begin
          state_d    = IDLE;
          walk_cnt_d = '0;
        end else begin
          walk_cnt_d = walk_cnt_q + CNT_BITS'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        walk_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      walk_cnt_q  <= '0;
      free_req_q  <= '0;
      free_preg_q <= '0;
      for (int i = 0; i < NUM_ARCH_REGS; i++) rrat_q[i] <= PREG_BITS'(i);
    end else begin
      state_q     <= state_d;
      walk_cnt_q  <= walk_cnt_d;
      free_req_q  <= free_req_d;
      free_preg_q <= free_preg_d;
      rrat_q      <= rrat_d;
    end
  end

  assign free_req  = free_req_q;
  assign free_preg = free_preg_q;

  // Walk outputs read rrat directly; it cannot change while commit_ready is low.
  assign walk_valid     = (state_q == WALK);
  assign busy           = (state_q == WALK);
  assign walk_done      = (state_q == WALK) && (walk_cnt_q == LAST_BEAT);
  assign walk_arch_base = 5'(walk_cnt_q) * 5'(WALK_WIDTH);

  always_comb begin
    walk_preg = '0;
    for (int k = 0; k < WALK_WIDTH; k++) begin
      walk_preg[k] = rrat_q[walk_arch_base + 5'(k)];
    end
  end

`ifdef FREE_STATS_EN
  logic [31:0] freed_total_q, freed_total_d;

  always_comb begin
    freed_total_d = freed_total_q;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (free_req_q[k]) freed_total_d = freed_total_d + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) freed_total_q <= '0;
    else     freed_total_q <= freed_total_d;
  end

  assign freed_total = freed_total_q;
`else
  assign freed_total = '0;
`endif

endmodule

// File: tb/tb_commit_preg_release.sv
// Directed bench for commit_preg_release: commit vectors table, then recovery walks with and without mid-walk reset.
module tb_commit_preg_release;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [3:0]           commit_valid;
  logic [3:0]           commit_has_dest;
  logic [3:0][4:0]      commit_arch_rd;
  logic [3:0][5:0]      commit_new_preg;
  logic                 commit_ready;
  logic [3:0]           free_req;
  logic [3:0][5:0]      free_preg;
  logic                 recover_req;
  logic                 walk_valid;
  logic [4:0]           walk_arch_base;
  logic [3:0][5:0]      walk_preg;
  logic                 walk_done;
  logic                 busy;
  logic [31:0]          freed_total;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_map [32];
  int exp_total = 0;

  commit_preg_release dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_has_dest(commit_has_dest),
    .commit_arch_rd(commit_arch_rd), .commit_new_preg(commit_new_preg),
    .commit_ready(commit_ready), .free_req(free_req), .free_preg(free_preg),
    .recover_req(recover_req), .walk_valid(walk_valid), .walk_arch_base(walk_arch_base),
    .walk_preg(walk_preg), .walk_done(walk_done), .busy(busy), .freed_total(freed_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      valid;
    logic [3:0]      has;
    logic [3:0][4:0] rd;
    logic [3:0][5:0] np;
    logic [3:0]      exp_req;
    logic [3:0][5:0] exp_preg;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_commits();
    commit_valid    = '0;
    commit_has_dest = '0;
    commit_arch_rd  = '0;
    commit_new_preg = '0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " walk_valid"}, 32'(walk_valid), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " commit_ready"}, 32'(commit_ready), 32'd1);
    chk({tag, " walk_done"}, 32'(walk_done), 32'd0);
  endtask

  // Runs a recovery walk; rst_at >= 0 asserts rst during that beat instead of finishing.
  task automatic run_walk(input bit with_commit, input int rst_at);
    logic [3:0][5:0] ep;
    @(negedge clk);
    clear_commits();
    recover_req = 1'b1;
    if (with_commit) begin
      commit_valid    = 4'b0001;
      commit_has_dest = 4'b0001;
      commit_arch_rd  = {5'd0, 5'd0, 5'd0, 5'd2};
      commit_new_preg = {6'd0, 6'd0, 6'd0, 6'd44};
    end
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      if (b == 0) begin
        if (with_commit) begin
          chk("pipelined free_req", 32'(free_req), 32'h1);
          chk("pipelined free_preg", 32'(free_preg), 32'd2);
          exp_total += 1;
        end
        // Offered during the walk: must be rejected and leave rrat untouched.
        commit_valid    = 4'b1111;
        commit_has_dest = 4'b1111;
        commit_arch_rd  = {5'd13, 5'd12, 5'd11, 5'd10};
        commit_new_preg = {6'd4, 6'd3, 6'd2, 6'd1};
      end
      if (b == 1) begin
        recover_req = 1'b0;
        chk("walk free_req idle", 32'(free_req), 32'd0);
      end
      for (int k = 0; k < 4; k++) ep[k] = exp_map[b*4 + k];
      chk($sformatf("beat%0d walk_valid", b), 32'(walk_valid), 32'd1);
      chk($sformatf("beat%0d base", b), 32'(walk_arch_base), 32'(b*4));
      chk($sformatf("beat%0d walk_preg", b), 32'(walk_preg), 32'(ep));
      chk($sformatf("beat%0d walk_done", b), 32'(walk_done), (b == 7) ? 32'd1 : 32'd0);
      chk($sformatf("beat%0d busy", b), 32'(busy), 32'd1);
      chk($sformatf("beat%0d commit_ready", b), 32'(commit_ready), 32'd0);
      if (b == rst_at) begin
        rst = 1'b1;
        clear_commits();
        @(negedge clk);
        rst = 1'b0;
        check_idle("post-rst");
        chk("post-rst free_req", 32'(free_req), 32'd0);
        return;
      end
      if (b == 7) clear_commits();
    end
    @(negedge clk);
    check_idle("post-walk");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // valid, has, rd{s3,s2,s1,s0}, new{s3..s0}, exp_req, exp_preg{l3..l0}
    vecs[0] = '{4'b0001, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, {6'd0, 6'd0, 6'd0, 6'd40},
                4'b0001, {6'd0, 6'd0, 6'd0, 6'd5}};
    vecs[1] = '{4'b0111, 4'b0111, {5'd0, 5'd7, 5'd3, 5'd3}, {6'd0, 6'd35, 6'd34, 6'd33},
                4'b0111, {6'd0, 6'd7, 6'd33, 6'd3}};
    vecs[2] = '{4'b1010, 4'b1010, {5'd9, 5'd0, 5'd8, 5'd0}, {6'd42, 6'd0, 6'd41, 6'd0},
                4'b0011, {6'd0, 6'd0, 6'd9, 6'd8}};
    vecs[3] = '{4'b0011, 4'b0001, {5'd0, 5'd0, 5'd4, 5'd0}, {6'd0, 6'd0, 6'd51, 6'd50},
                4'b0001, {6'd0, 6'd0, 6'd0, 6'd50}};
    vecs[4] = '{4'b1111, 4'b1111, {5'd3, 5'd0, 5'd5, 5'd5}, {6'd48, 6'd47, 6'd46, 6'd45},
                4'b1111, {6'd34, 6'd47, 6'd45, 6'd40}};
    vecs[5] = '{4'b0000, 4'b1111, {5'd1, 5'd2, 5'd3, 5'd4}, {6'd9, 6'd9, 6'd9, 6'd9},
                4'b0000, {6'd0, 6'd0, 6'd0, 6'd0}};
    vecs[6] = '{4'b1111, 4'b0000, {5'd1, 5'd2, 5'd3, 5'd4}, {6'd9, 6'd9, 6'd9, 6'd9},
                4'b0000, {6'd0, 6'd0, 6'd0, 6'd0}};
    vecs[7] = '{4'b0100, 4'b1111, {5'd1, 5'd31, 5'd3, 5'd4}, {6'd9, 6'd60, 6'd9, 6'd9},
                4'b0001, {6'd0, 6'd0, 6'd0, 6'd31}};

    rst = 1'b1;
    recover_req = 1'b0;
    clear_commits();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");
    chk("reset free_req", 32'(free_req), 32'd0);
    chk("reset free_preg", 32'(free_preg), 32'd0);
    chk("reset freed_total", freed_total, 32'd0);

    for (int v = 0; v < 8; v++) begin
      commit_valid    = vecs[v].valid;
      commit_has_dest = vecs[v].has;
      commit_arch_rd  = vecs[v].rd;
      commit_new_preg = vecs[v].np;
      @(negedge clk);
      clear_commits();
      chk($sformatf("vec%0d free_req", v), 32'(free_req), 32'(vecs[v].exp_req));
      chk($sformatf("vec%0d free_preg", v), 32'(free_preg), 32'(vecs[v].exp_preg));
      for (int k = 0; k < 4; k++) if (vecs[v].exp_req[k]) exp_total++;
    end
    @(negedge clk);
`ifdef FREE_STATS_EN
    chk("freed_total", freed_total, 32'(exp_total));
`else
    chk("freed_total", freed_total, 32'd0);
`endif

    for (int i = 0; i < 32; i++) exp_map[i] = 6'(i);
    exp_map[2]  = 6'd44;
    exp_map[3]  = 6'd48;
    exp_map[5]  = 6'd46;
    exp_map[7]  = 6'd35;
    exp_map[8]  = 6'd41;
    exp_map[9]  = 6'd42;
    exp_map[31] = 6'd60;
    run_walk(1'b1, -1);

    // Second walk confirms the map (including rrat[0]) is unchanged by the rejected commits.
    run_walk(1'b0, 3);

    for (int i = 0; i < 32; i++) exp_map[i] = 6'(i);
    run_walk(1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
